// File: rtl/moving_window_sum_pkg.sv
// Shared constants, width helpers and the per-edge operation type for the
// moving-window summer.
package mws_pkg;

  localparam int DEFAULT_W = 8;
  localparam int DEFAULT_N = 4;

  // What the window does on a given clock edge, already resolved by priority.
  typedef enum logic [1:0] {
    OP_HOLD,
    OP_FLUSH,
    OP_ACCEPT
  } win_op_e;

  function automatic int calc_log2n(input int n);
    return $clog2(n);
  endfunction

  // Wide enough to hold N full-scale samples without wrapping.
  function automatic int calc_ow(input int w, input int n);
    return w + $clog2(n);
  endfunction

endpackage

// File: rtl/moving_window_sum_if.sv
// Sample-in / result-out bundle of the moving-window summer.
// The master modport drives samples; the slave modport is the summer itself.
interface moving_window_sum_if
  import mws_pkg::*;
#(
  parameter int W = DEFAULT_W,
  parameter int N = DEFAULT_N
);

  localparam int LOG2N = calc_log2n(N);
  localparam int OW    = calc_ow(W, N);

  logic             clear;
  logic             in_valid;
  logic [W-1:0]     in;
  logic             avg_mode;
  logic [OW-1:0]    out;
  logic             out_valid;
  logic [LOG2N:0]   count;
  logic             full;

  modport master (
    output clear, in_valid, in, avg_mode,
    input  out, out_valid, count, full
  );

  modport slave (
    input  clear, in_valid, in, avg_mode,
    output out, out_valid, count, full
  );

endinterface

// File: rtl/window_ring_buf.sv
// N-deep ring of W-bit samples; exposes the sample about to be overwritten
// so the accumulator can subtract it in the same cycle.
module window_ring_buf #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int LOG2N = 2
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [LOG2N-1:0] wr_ptr,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     old_data
);

  logic [W-1:0] slots [N];

  // Zeroed slots make a partially filled window sum only the samples received.
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < N; i++) begin
        slots[i] <= '0;
      end
    end else if (wr_en) begin
      slots[wr_ptr] <= din;
    end
  end

  assign old_data = slots[wr_ptr];

endmodule

// File: rtl/moving_window_sum.sv
// Sliding sum (or floor average) over the last N accepted samples, with
// fill level, full flag and synchronous window flush.
module moving_window_sum
  import mws_pkg::*;
#(
  parameter int W = DEFAULT_W,
  parameter int N = DEFAULT_N
) (
  input logic               clk,
  input logic               reset,
  moving_window_sum_if.slave bus
);

  localparam int LOG2N = calc_log2n(N);
  localparam int OW    = calc_ow(W, N);
  localparam int CW    = LOG2N + 1;

  win_op_e          op;
  logic [W-1:0]     old_data;
  logic [OW-1:0]    acc;
  logic [OW-1:0]    acc_next;
  logic [OW-1:0]    out_value;
  logic [LOG2N-1:0] wp;
  logic [LOG2N-1:0] wp_next;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;
  logic [OW-1:0]    out_q;
  logic             out_valid_q;

  // Reset and clear share one flush path; a sample arriving alongside is dropped.
  always_comb begin
    op = OP_HOLD;
    if (reset || bus.clear) begin
      op = OP_FLUSH;
    end else if (bus.in_valid) begin
      op = OP_ACCEPT;
    end
  end

  window_ring_buf #(
    .W     (W),
    .N     (N),
    .LOG2N (LOG2N)
  ) u_ring (
    .clk      (clk),
    .flush    (op == OP_FLUSH),
    .wr_en    (op == OP_ACCEPT),
    .wr_ptr   (wp),
    .din      (bus.in),
    .old_data (old_data)
  );

  // acc always covers old_data, so the subtraction never goes negative.
  always_comb begin
    acc_next   = acc + OW'(bus.in) - OW'(old_data);
    out_value  = bus.avg_mode ? (acc_next >> LOG2N) : acc_next;
    wp_next    = (wp == LOG2N'(N - 1)) ? '0 : wp + 1'b1;
    count_next = (count_q == CW'(N)) ? count_q : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (op == OP_FLUSH) begin
      acc         <= '0;
      wp          <= '0;
      count_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (op == OP_ACCEPT) begin
      acc         <= acc_next;
      wp          <= wp_next;
      count_q     <= count_next;
      out_q       <= out_value;
      out_valid_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.count     = count_q;
  assign bus.full      = (count_q == CW'(N));

endmodule

// File: tb/tb_moving_window_sum.sv
// Bench for moving_window_sum: a queue-based window model checked every cycle
// against two instances (W=8/N=4 and W=4/N=8), plus hand-computed vectors.
module tb_moving_window_sum;

  logic clk;
  logic rstA;
  logic rstB;

  int nChecks = 0;
  int nErrors = 0;

  int qA[$];
  int qB[$];
  int expOutA, expValidA;
  int expOutB, expValidB;

  moving_window_sum_if #(.W(8), .N(4)) ifA ();
  moving_window_sum_if #(.W(4), .N(8)) ifB ();

  moving_window_sum #(.W(8), .N(4)) dutA (
    .clk   (clk),
    .reset (rstA),
    .bus   (ifA)
  );

  moving_window_sum #(.W(4), .N(8)) dutB (
    .clk   (clk),
    .reset (rstB),
    .bus   (ifB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int windowSum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: the window is simply the last N accepted samples; flush empties it.
  always @(posedge clk) begin
    #1;
    if (rstA || ifA.clear) begin
      qA.delete();
      expOutA   = 0;
      expValidA = 0;
    end else if (ifA.in_valid) begin
      qA.push_back(int'(ifA.in));
      if (qA.size() > 4) void'(qA.pop_front());
      expOutA   = ifA.avg_mode ? windowSum(qA) / 4 : windowSum(qA);
      expValidA = 1;
    end else begin
      expValidA = 0;
    end

    if (rstB || ifB.clear) begin
      qB.delete();
      expOutB   = 0;
      expValidB = 0;
    end else if (ifB.in_valid) begin
      qB.push_back(int'(ifB.in));
      if (qB.size() > 8) void'(qB.pop_front());
      expOutB   = ifB.avg_mode ? windowSum(qB) / 8 : windowSum(qB);
      expValidB = 1;
    end else begin
      expValidB = 0;
    end

    checkOutput("A.out",       int'(ifA.out),       expOutA);
    checkOutput("A.out_valid", int'(ifA.out_valid), expValidA);
    checkOutput("A.count",     int'(ifA.count),     qA.size());
    checkOutput("A.full",      int'(ifA.full),      int'(qA.size() == 4));
    checkOutput("B.out",       int'(ifB.out),       expOutB);
    checkOutput("B.out_valid", int'(ifB.out_valid), expValidB);
    checkOutput("B.count",     int'(ifB.count),     qB.size());
    checkOutput("B.full",      int'(ifB.full),      int'(qB.size() == 8));
  end

  task automatic applyStimulus(input int v, input bit avg, input int expected);
    @(negedge clk);
    ifA.clear    = 1'b0;
    ifA.in_valid = 1'b1;
    ifA.in       = 8'(v);
    ifA.avg_mode = avg;
    @(posedge clk);
    #2;
    checkOutput("litA.out",   int'(ifA.out), expected);
    checkOutput("litA.model", expOutA,       expected);
  endtask

  task automatic sendB(input int v, input bit avg, input int expected);
    @(negedge clk);
    ifB.in_valid = 1'b1;
    ifB.in       = 4'(v);
    ifB.avg_mode = avg;
    @(posedge clk);
    #2;
    checkOutput("litB.out",   int'(ifB.out), expected);
    checkOutput("litB.model", expOutB,       expected);
  endtask

  task automatic idleA(input int cycles, input bit avg, input int holdOut);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      ifA.in_valid = 1'b0;
      ifA.in       = 8'd123;
      ifA.avg_mode = avg;
      @(posedge clk);
      #2;
      checkOutput("idleA.out",   int'(ifA.out),       holdOut);
      checkOutput("idleA.valid", int'(ifA.out_valid), 0);
    end
  endtask

  task automatic clearA();
    @(negedge clk);
    ifA.clear    = 1'b1;
    ifA.in_valid = 1'b1;
    ifA.in       = 8'd99;
    @(posedge clk);
    #2;
    checkOutput("clearA.out",   int'(ifA.out),       0);
    checkOutput("clearA.count", int'(ifA.count),     0);
    checkOutput("clearA.valid", int'(ifA.out_valid), 0);
    @(negedge clk);
    ifA.clear    = 1'b0;
    ifA.in_valid = 1'b0;
  endtask

  initial begin
    rstA = 1'b1;
    rstB = 1'b1;
    ifA.clear = 1'b0; ifA.in_valid = 1'b0; ifA.in = '0; ifA.avg_mode = 1'b0;
    ifB.clear = 1'b0; ifB.in_valid = 1'b0; ifB.in = '0; ifB.avg_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstA = 1'b0;
    rstB = 1'b0;
    checkOutput("reset.out",   int'(ifA.out),   0);
    checkOutput("reset.count", int'(ifA.count), 0);
    checkOutput("reset.full",  int'(ifA.full),  0);

    // Partial fill, then full once the fourth sample lands.
    applyStimulus(100, 0, 100);
    applyStimulus(100, 0, 200);
    applyStimulus(0,   0, 200);
    checkOutput("t1.full3", int'(ifA.full), 0);
    applyStimulus(50,  0, 250);
    checkOutput("t1.full4", int'(ifA.full), 1);
    applyStimulus(50,  0, 200);
    applyStimulus(250, 0, 350);

    // Full-scale samples reach the maximum without wrapping.
    clearA();
    for (int i = 0; i < 4; i++) applyStimulus(255, 0, 255 * (i + 1));
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 255 * (3 - i));
    checkOutput("t2.count", int'(ifA.count), 4);

    // A gap in the stream holds everything except the strobe.
    clearA();
    applyStimulus(10, 0, 10);
    applyStimulus(20, 0, 30);
    idleA(3, 0, 30);
    checkOutput("t3.count", int'(ifA.count), 2);
    applyStimulus(30, 0, 60);

    // Floor average divides by N even before the window is full.
    clearA();
    applyStimulus(10, 1, 2);
    applyStimulus(20, 1, 7);
    applyStimulus(30, 1, 15);
    applyStimulus(40, 1, 25);
    applyStimulus(50, 1, 35);
    idleA(2, 0, 35);

    // Flush by clear and by reset, with a sample presented alongside.
    clearA();
    applyStimulus(7, 0, 7);
    applyStimulus(8, 0, 15);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rstA = 1'b1;
      ifA.in_valid = 1'b1;
      ifA.in = 8'd77;
      @(posedge clk);
      #2;
      checkOutput("t5.rstOut",   int'(ifA.out),       0);
      checkOutput("t5.rstValid", int'(ifA.out_valid), 0);
    end
    @(negedge clk);
    rstA = 1'b0;
    ifA.in_valid = 1'b0;
    applyStimulus(5, 0, 5);

    // Deeper, narrower window saturates at 8 * 15.
    for (int i = 0; i < 9; i++) sendB(15, 0, 15 * ((i < 8) ? i + 1 : 8));
    checkOutput("t6.full", int'(ifB.full), 1);
    sendB(15, 1, 15);

    @(negedge clk);
    ifA.in_valid = 1'b0;
    ifB.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
